// File: rtl/pattern_sweeper_pkg.sv
// rtl/pattern_sweeper_pkg.sv - shared types and helpers for the exhaustive pattern sweeper
package pattern_sweeper_pkg;

  localparam int MAX_IN  = 8;
  localparam int MAX_OUT = 8;
  localparam int MAX_TBL = MAX_OUT << MAX_IN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sweep-order mapping from a linear vector index to the value driven on stim.
  function automatic logic [MAX_IN-1:0] to_code(input logic [MAX_IN-1:0] idx, input logic gray);
    return gray ? (idx ^ (idx >> 1)) : idx;
  endfunction

  // Expected response for stim value v; bits at and above n_out come back as zero.
  function automatic logic [MAX_OUT-1:0] exp_slice(input logic [MAX_TBL-1:0] tbl,
                                                   input logic [MAX_IN-1:0] v,
                                                   input int n_out);
    logic [MAX_OUT-1:0] r;
    logic [10:0]        pos;
    r = '0;
    for (int b = 0; b < MAX_OUT; b++) begin
      pos = 11'(v) * 11'(n_out) + 11'(b);
      if (b < n_out) r[b] = tbl[pos];
    end
    return r;
  endfunction

endpackage

// File: rtl/pattern_hold_timer.sv
// rtl/pattern_hold_timer.sv - per-vector hold counter with a last-hold-cycle strobe
module pattern_hold_timer #(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [HW-1:0] hold_cnt;

  assign last = en && (hold_cnt == HW'(HOLD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hold_cnt <= '0;
    end else if (en) begin
      hold_cnt <= last ? '0 : hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_sweeper.sv
// rtl/pattern_sweeper.sv - drives every input combination into a combinational DUT and checks it
module pattern_sweeper
  import pattern_sweeper_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int HOLD  = 10,
  parameter int GRAY  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [(N_OUT<<N_IN)-1:0] exp_table,
  input  logic [N_OUT-1:0]         dut_out,
  output logic [N_IN-1:0]          stim,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_IN:0]            err_cnt,
  output logic [N_IN-1:0]          first_err
);

  localparam int          N_VEC    = 1 << N_IN;
  localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(N_VEC - 1);

  state_t        state;
  logic [N_IN:0] idx;
  logic [N_IN:0] idx_nxt;
  logic          gray_en;
  logic          accept;
  logic          last;
  logic          mismatch;

  assign gray_en = (GRAY != 0);
  assign idx_nxt = idx + 1'b1;
  assign accept  = start && (state != RUN);

  // Upper bits of the table slice are zero, so comparing at full width is exact.
  assign mismatch = exp_slice(MAX_TBL'(exp_table), MAX_IN'(stim), N_OUT) != MAX_OUT'(dut_out);

  pattern_hold_timer #(
    .HOLD (HOLD)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .en    (state == RUN),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      first_err <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            idx       <= '0;
            stim      <= N_IN'(to_code('0, gray_en));
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
          end
        end
        RUN: begin
          if (last) begin
            if (mismatch) begin
              err_cnt <= err_cnt + 1'b1;
              if (err_cnt == '0) first_err <= stim;
            end
            if (idx == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              stim  <= '0;
              pass  <= (err_cnt == '0) && !mismatch;
            end else begin
              idx  <= idx_nxt;
              stim <= N_IN'(to_code(MAX_IN'(idx_nxt[N_IN-1:0]), gray_en));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sweeper.sv
// tb/tb_pattern_sweeper.sv - randomized self-checking bench for pattern_sweeper
module tb_pattern_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start;

  always #5 clk = ~clk;

  logic [1:0] fault [3][8];
  int gray_seq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  logic [2:0] stim_a, stim_b, first_a, first_b;
  logic [1:0] stim_c, first_c, dut_c;
  logic [3:0] err_a, err_b;
  logic [2:0] err_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic       dut_a, dut_b;

  // Bench-side DUTs: majority for a/b, {a&b, a^b} for c, each with injectable faults.
  assign dut_a = ($countones(stim_a) >= 2) ^ fault[0][stim_a][0];
  assign dut_b = ($countones(stim_b) >= 2) ^ fault[1][stim_b][0];
  assign dut_c = {stim_c[1] & stim_c[0], stim_c[1] ^ stim_c[0]} ^ fault[2][{1'b0, stim_c}];

  pattern_sweeper #(.N_IN(3), .N_OUT(1), .HOLD(10), .GRAY(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .exp_table(8'b1110_1000), .dut_out(dut_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .first_err(first_a));

  pattern_sweeper #(.N_IN(3), .N_OUT(1), .HOLD(1), .GRAY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .exp_table(8'b1110_1000), .dut_out(dut_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .first_err(first_b));

  pattern_sweeper #(.N_IN(2), .N_OUT(2), .HOLD(2), .GRAY(0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .exp_table(8'b10_01_01_00), .dut_out(dut_c),
    .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c), .first_err(first_c));

  logic [7:0] stim_o [3];
  logic [7:0] err_o [3];
  logic [7:0] first_o [3];
  logic [2:0] busy_o, done_o, pass_o;

  assign stim_o[0]  = 8'(stim_a);
  assign stim_o[1]  = 8'(stim_b);
  assign stim_o[2]  = 8'(stim_c);
  assign err_o[0]   = 8'(err_a);
  assign err_o[1]   = 8'(err_b);
  assign err_o[2]   = 8'(err_c);
  assign first_o[0] = 8'(first_a);
  assign first_o[1] = 8'(first_b);
  assign first_o[2] = 8'(first_c);
  assign busy_o = {busy_c, busy_b, busy_a};
  assign done_o = {done_c, done_b, done_a};
  assign pass_o = {pass_c, pass_b, pass_a};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int code_of(input int i, input int gray);
    return (gray != 0) ? gray_seq[i] : i;
  endfunction

  // One sweep on instance sel; abort_k / repulse_k < 0 disable reset-abort / start re-pulse.
  task automatic run_sweep(input int sel, input int n_in, input int hold, input int gray,
                           input int abort_k, input int repulse_k);
    int total, e_err, e_first, v;
    logic [1:0] nmask;
    total   = hold << n_in;
    nmask   = (sel == 2) ? 2'b11 : 2'b01;
    e_err   = 0;
    e_first = -1;
    for (int i = 0; i < (1 << n_in); i++) begin
      v = code_of(i, gray);
      if ((fault[sel][v] & nmask) != 2'b00) begin
        e_err++;
        if (e_first < 0) e_first = v;
      end
    end
    @(negedge clk);
    start[sel] = 1'b1;
    @(posedge clk);
    #1;
    start[sel] = 1'b0;
    check("start_pass_clear", 32'(pass_o[sel]), 0);
    for (int k = 0; k < total; k++) begin
      check("stim_seq", 32'(stim_o[sel]), 32'(code_of(k / hold, gray)));
      check("busy_run", 32'(busy_o[sel]), 1);
      check("done_run", 32'(done_o[sel]), 0);
      if (k == abort_k) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_stim", 32'(stim_o[sel]), 0);
        check("abort_busy", 32'(busy_o[sel]), 0);
        check("abort_err", 32'(err_o[sel]), 0);
        check("abort_done", 32'(done_o[sel]), 0);
        return;
      end
      start[sel] = (k == repulse_k);
      @(posedge clk);
      #1;
    end
    start[sel] = 1'b0;
    check("done_end", 32'(done_o[sel]), 1);
    check("busy_end", 32'(busy_o[sel]), 0);
    check("stim_end", 32'(stim_o[sel]), 0);
    check("err_cnt", 32'(err_o[sel]), 32'(e_err));
    check("pass", 32'(pass_o[sel]), 32'(e_err == 0));
    if (e_err > 0) check("first_err", 32'(first_o[sel]), 32'(e_first));
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    check("done_hold", 32'(done_o[sel]), 1);
    check("pass_hold", 32'(pass_o[sel]), 32'(e_err == 0));
  endtask

  task automatic clear_faults();
    for (int s = 0; s < 3; s++)
      for (int v = 0; v < 8; v++) fault[s][v] = 2'b00;
  endtask

  task automatic random_faults(input int sel, input int nvec);
    for (int v = 0; v < nvec; v++)
      fault[sel][v] = ($urandom_range(0, 3) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 3'b000;
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check("rst_stim", 32'(stim_o[s]), 0);
      check("rst_busy", 32'(busy_o[s]), 0);
      check("rst_done", 32'(done_o[s]), 0);
      check("rst_pass", 32'(pass_o[s]), 0);
      check("rst_err", 32'(err_o[s]), 0);
      check("rst_first", 32'(first_o[s]), 0);
    end
    rst_n = 1'b1;

    run_sweep(0, 3, 10, 0, -1, -1);
    fault[0][5] = 2'b01;
    fault[0][6] = 2'b01;
    run_sweep(0, 3, 10, 0, -1, 37);
    run_sweep(0, 3, 10, 0, 43, -1);
    clear_faults();
    run_sweep(0, 3, 10, 0, -1, -1);
    repeat (3) begin
      random_faults(0, 8);
      run_sweep(0, 3, 10, 0, -1, $urandom_range(1, 70));
    end

    run_sweep(1, 3, 1, 1, -1, -1);
    repeat (4) begin
      random_faults(1, 8);
      run_sweep(1, 3, 1, 1, -1, -1);
    end

    for (int v = 0; v < 4; v++) fault[2][v] = 2'($urandom_range(1, 3));
    run_sweep(2, 2, 2, 0, -1, -1);
    repeat (3) begin
      random_faults(2, 4);
      run_sweep(2, 2, 2, 0, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
